// File: rtl/mario_motion_ctrl.sv
// Mario player-motion controller: stand/walk/rise/fall machine advanced on a
// frame tick, with walk animation, facing, and variable-height jump offset.
module mario_motion_ctrl #(
    parameter int unsigned ID_W           = 6,
    parameter int unsigned Y_W            = 8,
    parameter int unsigned WALK_FRAMES    = 3,
    parameter int unsigned WALK_DIV       = 4,
    parameter int unsigned JUMP_TICKS     = 16,
    parameter int unsigned MIN_JUMP_TICKS = 4,
    parameter int unsigned RISE_STEP      = 2,
    parameter int unsigned FALL_STEP      = 2,
    parameter int unsigned ID_STAND       = 0,
    parameter int unsigned ID_WALK0       = 1,
    parameter int unsigned ID_JUMP        = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic            left,
    input  logic            right,
    input  logic            jump,
    output logic [ID_W-1:0] id,
    output logic            oriental,
    output logic            walk,
    output logic            rising,
    output logic            falling,
    output logic [Y_W-1:0]  y
);

    localparam int unsigned FRAME_W = (WALK_FRAMES > 1) ? $clog2(WALK_FRAMES) : 1;
    localparam int unsigned DIV_W   = (WALK_DIV > 1) ? $clog2(WALK_DIV) : 1;
    localparam int unsigned CNT_W   = $clog2(JUMP_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WALK,
        S_RISE,
        S_FALL
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   rise_cnt_q, rise_cnt_d;
    logic               armed_q, armed_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               oriental_q, oriental_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               walk_q, walk_d;
    logic               rising_q, rising_d;
    logic               falling_q, falling_d;
    logic               dir_valid;

    assign dir_valid = left ^ right;

    // Next-state, counter and registered-output computation for one tick.
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        div_d      = div_q;
        rise_cnt_d = rise_cnt_q;
        armed_d    = armed_q;
        y_d        = y_q;
        oriental_d = oriental_q;

        if (tick) begin
            if (dir_valid) begin
                oriental_d = left;
            end
            if (!jump) begin
                armed_d = 1'b1;
            end
            case (state_q)
                S_IDLE, S_WALK: begin
                    if (jump && armed_q) begin
                        // jump wins over walking; holding jump cannot re-arm
                        state_d    = S_RISE;
                        armed_d    = 1'b0;
                        y_d        = Y_W'(RISE_STEP);
                        rise_cnt_d = CNT_W'(1);
                    end else if (state_q == S_IDLE) begin
                        if (dir_valid) begin
                            state_d = S_WALK;
                            frame_d = '0;
                            div_d   = '0;
                        end
                    end else if (!dir_valid) begin
                        state_d = S_IDLE;
                    end else if (div_q == DIV_W'(WALK_DIV - 1)) begin
                        div_d   = '0;
                        frame_d = (frame_q == FRAME_W'(WALK_FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
                    end else begin
                        div_d = div_q + DIV_W'(1);
                    end
                end
                S_RISE: begin
                    if ((rise_cnt_q == CNT_W'(JUMP_TICKS)) ||
                        (!jump && (rise_cnt_q >= CNT_W'(MIN_JUMP_TICKS)))) begin
                        state_d = S_FALL;
                    end else begin
                        y_d        = y_q + Y_W'(RISE_STEP);
                        rise_cnt_d = rise_cnt_q + CNT_W'(1);
                    end
                end
                S_FALL: begin
                    // clamp at ground rather than wrapping below zero
                    if (y_q <= Y_W'(FALL_STEP)) begin
                        y_d = '0;
                        if (dir_valid) begin
                            state_d = S_WALK;
                            frame_d = '0;
                            div_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        y_d = y_q - Y_W'(FALL_STEP);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        walk_d    = (state_d == S_WALK);
        rising_d  = (state_d == S_RISE);
        falling_d = (state_d == S_FALL);
        case (state_d)
            S_WALK:         id_d = ID_W'(ID_WALK0) + ID_W'(frame_d);
            S_RISE, S_FALL: id_d = ID_W'(ID_JUMP);
            default:        id_d = ID_W'(ID_STAND);
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            frame_q    <= '0;
            div_q      <= '0;
            rise_cnt_q <= '0;
            armed_q    <= 1'b1;
            y_q        <= '0;
            oriental_q <= 1'b0;
            id_q       <= ID_W'(ID_STAND);
            walk_q     <= 1'b0;
            rising_q   <= 1'b0;
            falling_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            div_q      <= div_d;
            rise_cnt_q <= rise_cnt_d;
            armed_q    <= armed_d;
            y_q        <= y_d;
            oriental_q <= oriental_d;
            id_q       <= id_d;
            walk_q     <= walk_d;
            rising_q   <= rising_d;
            falling_q  <= falling_d;
        end
    end

    assign id       = id_q;
    assign oriental = oriental_q;
    assign walk     = walk_q;
    assign rising   = rising_q;
    assign falling  = falling_q;
    assign y        = y_q;

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Bench for mario_motion_ctrl: directed scenarios with literal expectations
// plus randomized button/tick stimulus against a behavioural model.
module tb_mario_motion_ctrl;

    localparam int ID_W = 6;
    localparam int Y_W  = 8;
    localparam int WF   = 3;
    localparam int WD   = 4;
    localparam int JT   = 16;
    localparam int MJ   = 4;
    localparam int RS   = 2;
    localparam int FS   = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            tick = 1'b0;
    logic            left = 1'b0;
    logic            right = 1'b0;
    logic            jump = 1'b0;
    logic [ID_W-1:0] id;
    logic            oriental;
    logic            walk;
    logic            rising;
    logic            falling;
    logic [Y_W-1:0]  y;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    mario_motion_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .left     (left),
        .right    (right),
        .jump     (jump),
        .id       (id),
        .oriental (oriental),
        .walk     (walk),
        .rising   (rising),
        .falling  (falling),
        .y        (y)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 stand, 1 walk, 2 rise, 3 fall.
    int m_mode = 0;
    int m_wt   = 0;   // ticks spent walking since entering the walk
    int m_rc   = 0;
    int m_y    = 0;
    int m_ori  = 0;
    int m_arm  = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_wt = 0; m_rc = 0; m_y = 0; m_ori = 0; m_arm = 1;
        end else if (tick) begin
            automatic bit dv = left ^ right;
            if (dv) m_ori = left ? 1 : 0;
            if ((m_mode == 0 || m_mode == 1) && jump && m_arm == 1) begin
                m_mode = 2; m_y = RS; m_rc = 1; m_arm = 0;
            end else if (m_mode == 0) begin
                if (dv) begin m_mode = 1; m_wt = 0; end
            end else if (m_mode == 1) begin
                if (!dv) m_mode = 0; else m_wt++;
            end else if (m_mode == 2) begin
                if (m_rc == JT || (!jump && m_rc >= MJ)) m_mode = 3;
                else begin m_y += RS; m_rc++; end
            end else begin
                if (m_y <= FS) begin
                    m_y = 0;
                    if (dv) begin m_mode = 1; m_wt = 0; end else m_mode = 0;
                end else m_y -= FS;
            end
            if (!jump) m_arm = 1;
        end
    end

    function automatic int exp_id();
        if (m_mode == 0) return 0;
        if (m_mode == 1) return 1 + (m_wt / WD) % WF;
        return 4;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            automatic int e_id = exp_id();
            n_vec++;
            if (int'(id) != e_id || int'(oriental) != m_ori || walk != (m_mode == 1) ||
                rising != (m_mode == 2) || falling != (m_mode == 3) || int'(y) != m_y) begin
                n_err++;
                $display("FAIL model: id=%0d ori=%0d w=%0d r=%0d f=%0d y=%0d, expected id=%0d ori=%0d mode=%0d y=%0d at %0t",
                         id, oriental, walk, rising, falling, y, e_id, m_ori, m_mode, m_y, $time);
            end
        end
    end

    // One tick with given buttons, then gap idle cycles with noise on buttons.
    task automatic tk(input bit l, input bit r, input bit j, input int gap);
        tick = 1'b1; left = l; right = r; jump = j;
        @(posedge clk); #1;
        if (gap > 0) begin
            tick = 1'b0;
            for (int g = 0; g < gap; g++) begin
                left = 1'($urandom); right = 1'($urandom); jump = 1'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    int walk_ids[13] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1};
    int tap_y[9]     = '{2, 4, 6, 8, 8, 6, 4, 2, 0};

    initial begin
        bit rl, rr, rj;

        // Reset with no clock edge
        #1 rst = 1'b1;
        #1;
        chk("rst_id", int'(id), 0);
        chk("rst_flags", int'({oriental, walk, rising, falling}), 0);
        chk("rst_y", int'(y), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        // Walk right, tick every 4 clk
        for (int i = 0; i < 13; i++) begin
            tk(1'b0, 1'b1, 1'b0, 3);
            chk("walk_id", int'(id), walk_ids[i]);
            chk("walk_flag", int'(walk), 1);
            chk("walk_ori", int'(oriental), 0);
        end
        tk(1'b0, 1'b0, 1'b0, 3);
        chk("walk_release_id", int'(id), 0);
        chk("walk_release_flag", int'(walk), 0);

        // Tap jump
        for (int i = 0; i < 9; i++) begin
            tk(1'b0, 1'b0, (i == 0), 1);
            chk("tap_y", int'(y), tap_y[i]);
            chk("tap_rising", int'(rising), (i < 4) ? 1 : 0);
            chk("tap_falling", int'(falling), (i >= 4 && i < 8) ? 1 : 0);
            chk("tap_id", int'(id), (i < 8) ? 4 : 0);
        end

        // Held jump for 40 ticks, continuous tick
        for (int i = 1; i <= 40; i++) begin
            tk(1'b0, 1'b0, 1'b1, 0);
            if (i == 16) chk("held_peak", int'(y), 32);
            if (i == 17) chk("held_fall_start", int'(falling), 1);
            if (i >= 33) begin
                chk("held_ground_y", int'(y), 0);
                chk("held_no_retrigger", int'(rising), 0);
            end
        end
        tk(1'b0, 1'b0, 1'b0, 0);
        tk(1'b0, 1'b0, 1'b1, 2);
        chk("rejump_rising", int'(rising), 1);
        chk("rejump_y", int'(y), 2);

        // Fall with left held, land walking
        for (int i = 0; i < 4; i++) tk(1'b0, 1'b0, 1'b0, 2);
        chk("fall_enter", int'(falling), 1);
        chk("fall_y", int'(y), 8);
        tk(1'b1, 1'b0, 1'b0, 2);
        chk("fall_left_ori", int'(oriental), 1);
        chk("fall_left_id", int'(id), 4);
        for (int i = 0; i < 3; i++) tk(1'b1, 1'b0, 1'b0, 1);
        chk("land_walk", int'(walk), 1);
        chk("land_id", int'(id), 1);

        // Both directions in IDLE
        tk(1'b0, 1'b0, 1'b0, 1);
        tk(1'b1, 1'b1, 1'b0, 1);
        chk("both_walk", int'(walk), 0);
        chk("both_ori", int'(oriental), 1);

        // Asynchronous reset mid-jump at y=20
        for (int i = 0; i < 10; i++) tk(1'b0, 1'b0, 1'b1, 1);
        chk("pre_rst_y", int'(y), 20);
        #2 rst = 1'b1;
        #1;
        chk("midrst_y", int'(y), 0);
        chk("midrst_id", int'(id), 0);
        chk("midrst_flags", int'({oriental, walk, rising, falling}), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tk(1'b0, 1'b0, 1'b1, 1);
        chk("post_rst_rising", int'(rising), 1);
        chk("post_rst_y", int'(y), 2);

        // Randomized stimulus against the model
        rl = 0; rr = 0; rj = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) rl = 1'($urandom);
            if ($urandom_range(0, 3) == 0) rr = 1'($urandom);
            if ($urandom_range(0, 5) == 0) rj = ~rj;
            tk(rl, rr, rj, $urandom_range(0, 3));
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
